// File: rtl/mux_arbiter.sv
// Two-source burst arbiter driving a shared, registered 2:1 datapath.
// Alternates ownership under contention and caps each grant at MAX_BURST beats.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic             last0,
  input  logic             last1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(MAX_BURST - 1);

  state_t           r_state;
  logic [3:0]       r_count;
  logic             r_last_owner;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  state_t           w_next_state;
  logic             w_granted;
  logic             w_owner_id;
  logic             w_req_own;
  logic             w_last_own;
  logic             w_out_free;
  logic             w_accept;
  logic             w_grant_end;

  // Tie goes to whichever source did not own the previous grant.
  function automatic state_t arb(input logic a0, input logic a1, input logic owner);
    state_t result;
    result = IDLE;
    if (a0 && a1)  result = owner ? G0 : G1;
    else if (a0)   result = G0;
    else if (a1)   result = G1;
    return result;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    w_granted    = (r_state != IDLE);
    w_owner_id   = (r_state == G1);
    w_req_own    = w_owner_id ? req1 : req0;
    w_last_own   = w_owner_id ? last1 : last0;
    w_out_free   = !r_dout_valid || dout_ready;
    w_accept     = w_granted && w_req_own && w_out_free;
    w_grant_end  = w_granted &&
                   (!w_req_own || (w_accept && (w_last_own || r_count == LIMIT)));
    w_next_state = r_state;
    if (!w_granted)       w_next_state = arb(req0, req1, r_last_owner);
    else if (w_grant_end) w_next_state = arb(req0, req1, w_owner_id);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_last_owner <= 1'b1;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Counter restarts on every fresh grant, including a re-grant to the same owner.
      if (!w_granted || w_grant_end) r_count <= '0;
      else if (w_accept)             r_count <= r_count + 4'd1;

      if (w_grant_end) r_last_owner <= w_owner_id;

      if (w_accept) begin
        r_dout       <= w_owner_id ? din1 : din0;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign gnt0       = (r_state == G0);
  assign gnt1       = (r_state == G1);
  assign sel        = (r_state == G0);
  assign busy       = (r_state != IDLE);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: MAX_BURST=4 instance for most scenarios,
// MAX_BURST=1 instance for strict alternation.
module tb_mux_arbiter;

  typedef struct packed {
    logic       r0, r1, l0, l1, rdy;
    logic [7:0] d0, d1;
    logic       g0, g1, v;
    logic [7:0] dout;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, last0 = 0, last1 = 0, dout_ready = 1;
  logic [7:0] din0 = '0, din1 = '0;
  logic       gnt0, gnt1, sel, busy, dout_valid;
  logic [7:0] dout;

  logic       b_req0 = 0, b_req1 = 0, b_last0 = 0, b_last1 = 0, b_ready = 1;
  logic [7:0] b_din0 = '0, b_din1 = '0;
  logic       b_gnt0, b_gnt1, b_sel, b_busy, b_valid;
  logic [7:0] b_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .last0(last0), .last1(last1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  mux_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .req1(b_req1), .din0(b_din0), .din1(b_din1),
    .last0(b_last0), .last1(b_last1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel),
    .dout(b_dout), .dout_valid(b_valid), .dout_ready(b_ready), .busy(b_busy)
  );

  function automatic step_t mk(input logic r0, input logic r1, input logic l0,
                               input logic l1, input logic rdy,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic g0, input logic g1, input logic v,
                               input logic [7:0] dexp);
    step_t s;
    s.r0 = r0; s.r1 = r1; s.l0 = l0; s.l1 = l1; s.rdy = rdy;
    s.d0 = d0; s.d1 = d1;
    s.g0 = g0; s.g1 = g1; s.v = v; s.dout = dexp;
    return s;
  endfunction

  task automatic drive(input step_t s);
    req0 = s.r0; req1 = s.r1; last0 = s.l0; last1 = s.l1;
    dout_ready = s.rdy; din0 = s.d0; din1 = s.d1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h00));
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] exp_f;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; b_req0 = 1'b1; b_req1 = 1'b1;
    #12;
    exp_f = 5'b00000;
    if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: got flags=%b dout=%h expected flags=%b dout=00",
               {gnt0, gnt1, sel, busy, dout_valid}, dout, exp_f);
    end
    checks++;
    if ({b_gnt0, b_gnt1, b_sel, b_busy, b_valid} !== exp_f || b_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: got flags=%b dout=%h expected flags=%b dout=00",
               {b_gnt0, b_gnt1, b_sel, b_busy, b_valid}, b_dout, exp_f);
    end
    checks++;
    req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f) begin
      errors++;
      $display("FAIL reset_release_idle: got flags=%b expected flags=%b",
               {gnt0, gnt1, sel, busy, dout_valid}, exp_f);
    end
    checks++;
  endtask

  // Single packet 0x11,0x22,0x33 from source 0; re-granted on last then aborts to IDLE.
  task automatic test_single_packet();
    step_t s[$];
    logic [4:0] exp_f;
    s.push_back(mk(1, 0, 0, 0, 1, 8'h11, 8'h00, 1, 0, 0, 8'h00));
    s.push_back(mk(1, 0, 0, 0, 1, 8'h11, 8'h00, 1, 0, 1, 8'h11));
    s.push_back(mk(1, 0, 0, 0, 1, 8'h22, 8'h00, 1, 0, 1, 8'h22));
    s.push_back(mk(1, 0, 1, 0, 1, 8'h33, 8'h00, 1, 0, 1, 8'h33));
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h33));
    foreach (s[k]) begin
      drive(s[k]);
      tick();
      exp_f = {s[k].g0, s[k].g1, s[k].g0, s[k].g0 | s[k].g1, s[k].v};
      if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f || dout !== s[k].dout) begin
        errors++;
        $display("FAIL single_packet step %0d: got flags=%b dout=%h expected flags=%b dout=%h",
                 k, {gnt0, gnt1, sel, busy, dout_valid}, dout, exp_f, s[k].dout);
      end
      checks++;
    end
  endtask

  // Simultaneous requests after reset: G0 first, then G1 with no bubble after last0.
  task automatic test_tie_break();
    step_t s[$];
    logic [4:0] exp_f;
    apply_reset();
    s.push_back(mk(1, 1, 0, 0, 1, 8'hA0, 8'hB0, 1, 0, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 0, 1, 8'hA0, 8'hB0, 1, 0, 1, 8'hA0));
    s.push_back(mk(1, 1, 1, 0, 1, 8'hA1, 8'hB0, 0, 1, 1, 8'hA1));
    s.push_back(mk(0, 1, 0, 1, 1, 8'h00, 8'hB1, 0, 1, 1, 8'hB1));
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 8'hB1));
    foreach (s[k]) begin
      drive(s[k]);
      tick();
      exp_f = {s[k].g0, s[k].g1, s[k].g0, s[k].g0 | s[k].g1, s[k].v};
      if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f || dout !== s[k].dout) begin
        errors++;
        $display("FAIL tie_break step %0d: got flags=%b dout=%h expected flags=%b dout=%h",
                 k, {gnt0, gnt1, sel, busy, dout_valid}, dout, exp_f, s[k].dout);
      end
      checks++;
    end
  endtask

  // Source 1 has 6 beats: 4-beat cap forces G0, then the remaining 2 beats follow.
  task automatic test_max_burst();
    step_t s[$];
    logic [4:0] exp_f;
    s.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'h60, 0, 1, 0, 8'hB1));
    s.push_back(mk(1, 1, 1, 0, 1, 8'h70, 8'h60, 0, 1, 1, 8'h60));
    s.push_back(mk(1, 1, 1, 0, 1, 8'h70, 8'h61, 0, 1, 1, 8'h61));
    s.push_back(mk(1, 1, 1, 0, 1, 8'h70, 8'h62, 0, 1, 1, 8'h62));
    s.push_back(mk(1, 1, 1, 0, 1, 8'h70, 8'h63, 1, 0, 1, 8'h63));
    s.push_back(mk(1, 1, 1, 0, 1, 8'h70, 8'h64, 0, 1, 1, 8'h70));
    s.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'h64, 0, 1, 1, 8'h64));
    s.push_back(mk(0, 1, 0, 1, 1, 8'h00, 8'h65, 0, 1, 1, 8'h65));
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h65));
    foreach (s[k]) begin
      drive(s[k]);
      tick();
      exp_f = {s[k].g0, s[k].g1, s[k].g0, s[k].g0 | s[k].g1, s[k].v};
      if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f || dout !== s[k].dout) begin
        errors++;
        $display("FAIL max_burst step %0d: got flags=%b dout=%h expected flags=%b dout=%h",
                 k, {gnt0, gnt1, sel, busy, dout_valid}, dout, exp_f, s[k].dout);
      end
      checks++;
    end
  endtask

  // dout_ready low for 3 cycles holds 0xA5 and blocks the next accept.
  task automatic test_backpressure();
    step_t s[$];
    logic [4:0] exp_f;
    s.push_back(mk(1, 0, 0, 0, 1, 8'hA5, 8'h00, 1, 0, 0, 8'h65));
    s.push_back(mk(1, 0, 0, 0, 1, 8'hA5, 8'h00, 1, 0, 1, 8'hA5));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h5A, 8'h00, 1, 0, 1, 8'hA5));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h5A, 8'h00, 1, 0, 1, 8'hA5));
    s.push_back(mk(1, 0, 0, 0, 0, 8'h5A, 8'h00, 1, 0, 1, 8'hA5));
    s.push_back(mk(1, 0, 1, 0, 1, 8'h5A, 8'h00, 1, 0, 1, 8'h5A));
    s.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h5A));
    foreach (s[k]) begin
      drive(s[k]);
      tick();
      exp_f = {s[k].g0, s[k].g1, s[k].g0, s[k].g0 | s[k].g1, s[k].v};
      if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f || dout !== s[k].dout) begin
        errors++;
        $display("FAIL backpressure step %0d: got flags=%b dout=%h expected flags=%b dout=%h",
                 k, {gnt0, gnt1, sel, busy, dout_valid}, dout, exp_f, s[k].dout);
      end
      checks++;
    end
  endtask

  // Reset pulsed during beat 2 of a G1 packet; no grant before the first edge after release.
  task automatic test_reset_mid_packet();
    step_t s[$];
    logic [4:0] exp_f;
    s.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'hC1, 0, 1, 0, 8'h5A));
    s.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'hC1, 0, 1, 1, 8'hC1));
    foreach (s[k]) begin
      drive(s[k]);
      tick();
      exp_f = {s[k].g0, s[k].g1, s[k].g0, s[k].g0 | s[k].g1, s[k].v};
      if ({gnt0, gnt1, sel, busy, dout_valid} !== exp_f || dout !== s[k].dout) begin
        errors++;
        $display("FAIL reset_mid_packet setup step %0d: got flags=%b dout=%h expected flags=%b dout=%h",
                 k, {gnt0, gnt1, sel, busy, dout_valid}, dout, exp_f, s[k].dout);
      end
      checks++;
    end
    din1 = 8'hC2;
    req0 = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    if ({gnt0, gnt1, sel, busy, dout_valid} !== 5'b00000 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_assert: got flags=%b dout=%h expected flags=00000 dout=00",
               {gnt0, gnt1, sel, busy, dout_valid}, dout);
    end
    checks++;
    tick();
    if ({gnt0, gnt1, sel, busy, dout_valid} !== 5'b00000 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_held_over_edge: got flags=%b dout=%h expected flags=00000 dout=00",
               {gnt0, gnt1, sel, busy, dout_valid}, dout);
    end
    checks++;
    #3;
    rst_n = 1'b1;
    #1;
    if ({gnt0, gnt1, sel, busy, dout_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_release_no_early_grant: got flags=%b expected flags=00000",
               {gnt0, gnt1, sel, busy, dout_valid});
    end
    checks++;
    tick();
    if ({gnt0, gnt1, sel, busy, dout_valid} !== 5'b10110 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_grant_tie: got flags=%b dout=%h expected flags=10110 dout=00",
               {gnt0, gnt1, sel, busy, dout_valid}, dout);
    end
    checks++;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    if ({gnt0, gnt1, sel, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_abort_idle: got flags=%b expected flags=0000",
               {gnt0, gnt1, sel, busy});
    end
    checks++;
  endtask

  // MAX_BURST=1 instance with both sources requesting: grants alternate every beat.
  task automatic test_alternate_burst1();
    logic [4:0] exp_f;
    logic [7:0] exp_d;
    b_din0 = 8'h0A; b_din1 = 8'h0B; b_last0 = 1'b0; b_last1 = 1'b0; b_ready = 1'b1;
    b_req0 = 1'b1; b_req1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_f = (k % 2 == 1) ? 5'b10110 : 5'b01010;
      if (k > 1) exp_f[0] = 1'b1;
      exp_d = (k == 1) ? 8'h00 : ((k % 2 == 0) ? 8'h0A : 8'h0B);
      if ({b_gnt0, b_gnt1, b_sel, b_busy, b_valid} !== exp_f || b_dout !== exp_d) begin
        errors++;
        $display("FAIL alternate_burst1 beat %0d: got flags=%b dout=%h expected flags=%b dout=%h",
                 k, {b_gnt0, b_gnt1, b_sel, b_busy, b_valid}, b_dout, exp_f, exp_d);
      end
      checks++;
    end
    b_req0 = 1'b0;
    b_req1 = 1'b0;
    tick();
    if ({b_gnt0, b_gnt1, b_sel, b_busy, b_valid} !== 5'b00000 || b_dout !== 8'h0A) begin
      errors++;
      $display("FAIL alternate_burst1 idle: got flags=%b dout=%h expected flags=00000 dout=0a",
               {b_gnt0, b_gnt1, b_sel, b_busy, b_valid}, b_dout);
    end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_packet();
    test_tie_break();
    test_max_burst();
    test_backpressure();
    test_reset_mid_packet();
    test_alternate_burst1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
